// File: rtl/cardinal_pkg.sv
// rtl/cardinal_pkg.sv - shared Cardinal pipeline constants and fetch FSM state type
package cardinal_pkg;

    localparam logic [5:0] OP_R    = 6'b101010;
    localparam logic [5:0] OP_LD   = 6'b100000;
    localparam logic [5:0] OP_ST   = 6'b100001;
    localparam logic [5:0] OP_BEZ  = 6'b100010;
    localparam logic [5:0] OP_BNEZ = 6'b100011;
    localparam logic [5:0] OP_NOP  = 6'b111000;

    localparam logic [31:0] NOP_INSTR = {OP_NOP, 26'd0};

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_RUN   = 2'd1,
        S_REDIR = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_t;

    function automatic logic [5:0] opcode_of(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/if_fetch_unit_if.sv
// rtl/if_fetch_unit_if.sv - instruction memory port and IF/ID delivery bus of the fetch stage
interface if_fetch_unit_if #(
    parameter int PC_W = 32
) ();

    logic [0:PC_W-1] imem_addr;
    logic            imem_en;
    logic [31:0]     imem_rdata;
    logic [31:0]     IF_Instr;
    logic [0:PC_W-1] IF_PC;
    logic            IF_valid;
    logic            flush;

    modport master (
        output imem_addr,
        output imem_en,
        input  imem_rdata,
        output IF_Instr,
        output IF_PC,
        output IF_valid,
        output flush
    );

    modport slave (
        input  imem_addr,
        input  imem_en,
        output imem_rdata,
        input  IF_Instr,
        input  IF_PC,
        input  IF_valid,
        input  flush
    );

endinterface

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC ownership, imem drive, stall/redirect/halt handling
module if_fetch_unit
    import cardinal_pkg::*;
#(
    parameter int              PC_W     = 32,
    parameter int              PC_STEP  = 4,
    parameter logic [0:PC_W-1] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             br_taken,
    input  logic [0:15]      br_target,
    input  logic             halt,
    output logic [CNT_W-1:0] fetch_cnt,
    if_fetch_unit_if.master  bus
);

    localparam logic [0:PC_W-1] STEP = PC_W'(PC_STEP);

    fetch_state_t    state_q, state_d;
    logic [0:PC_W-1] pc_q, pc_d;
    logic [0:PC_W-1] ipc_q, ipc_d;
    logic [CNT_W-1:0] cnt_q;

    logic [31:0]     instr;
    logic [0:PC_W-1] if_pc;
    logic            valid;
    logic            flush_o;
    logic            en;
    logic [0:PC_W-1] addr;
    logic            accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FILL;
            pc_q    <= RESET_PC;
            ipc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ipc_q   <= ipc_d;
            if (accept) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ipc_d   = ipc_q;
        instr   = NOP_INSTR;
        if_pc   = ipc_q;
        valid   = 1'b0;
        flush_o = 1'b0;
        en      = 1'b1;
        addr    = pc_q;

        unique case (state_q)
            S_FILL, S_REDIR: begin
                if (br_taken) begin
                    flush_o = 1'b1;
                    pc_d    = {{(PC_W-16){1'b0}}, br_target};
                    state_d = S_REDIR;
                end else if (halt) begin
                    state_d = S_HALT;
                end else if (!stall) begin
                    ipc_d   = pc_q;
                    pc_d    = pc_q + STEP;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                instr = bus.imem_rdata;
                valid = 1'b1;
                if (br_taken) begin
                    flush_o = 1'b1;
                    pc_d    = {{(PC_W-16){1'b0}}, br_target};
                    state_d = S_REDIR;
                end else if (halt) begin
                    state_d = S_HALT;
                end else if (stall) begin
                    // Re-read the held address so imem_rdata still carries it the cycle stall drops.
                    addr = ipc_q;
                end else begin
                    ipc_d = pc_q;
                    pc_d  = pc_q + STEP;
                end
            end

            S_HALT: begin
                en = 1'b0;
            end

            default: begin
                state_d = S_FILL;
            end
        endcase
    end

    assign accept = valid & ~stall & ~flush_o;

    assign bus.imem_addr = addr;
    assign bus.imem_en   = en;
    assign bus.IF_Instr  = instr;
    assign bus.IF_PC     = if_pc;
    assign bus.IF_valid  = valid;
    assign bus.flush     = flush_o;
    assign fetch_cnt     = cnt_q;

endmodule
